clock_monitor: RTL
==================

Name: clock_monitor

Overview:
Receiving end for the catalog `clock` generator. It samples an asynchronous clock-like input (`sig_in`) in the system `clk` domain and measures its period and high time in `clk` cycles. It also reports lock (a stable period) and stuck (no rising edge within a timeout). It is used as a catalog self-check element and as a frequency sanity monitor on generated or divided clocks.

Parameters:
CNT_WIDTH, 16, width of the cycle counter and of the period/high_time outputs.
SYNC_STAGES, 2, number of flops in the `sig_in` synchronizer chain (minimum 2).
TIMEOUT, 1024, `clk` cycles without a rising edge before stuck is flagged; must be less than 2**CNT_WIDTH - 1.
TOL, 0, maximum allowed |period - prev_period| for lock.

Ports:
clk  input  1  system clock; all state updates on the rising edge.
rst  input  1  synchronous, active-high reset.
enable  input  1  monitor enable; when low, the FSM is held in IDLE.
sig_in  input  1  monitored clock, asynchronous to clk.
period  output  CNT_WIDTH  last measured rise-to-rise interval in clk cycles.
high_time  output  CNT_WIDTH  last measured rise-to-fall interval in clk cycles.
valid  output  1  one-cycle pulse when period/high_time update.
locked  output  1  period stable within TOL across consecutive measurements.
stuck  output  1  no rising edge seen for TIMEOUT cycles.

Behaviour:
- Interface: one clock `clk`; reset `rst` is synchronous and active-high.
- Reset: period=0, high_time=0, valid=0, locked=0, stuck=0. Counter, prev_period and the synchronizer chain are cleared; the FSM goes to IDLE. Reset mid-measurement discards the partial result with no valid pulse.
- Synchronizer: s[0..SYNC_STAGES-1] followed by a prev flop.
  - rise = s[last] & ~prev; fall = ~s[last] & prev.
  - If sig_in is first sampled high at clk edge k, rise is true in the cycle after edge k+SYNC_STAGES-1. Outputs update at edge k+SYNC_STAGES.
- Each sig_in phase must last at least 2 clk cycles. Shorter pulses may be missed; this is not an error condition.
- FSM states: IDLE, WAIT_RISE, FIRST, MEASURE.
  - IDLE: cnt held at 0. When enable=1, go to WAIT_RISE.
  - WAIT_RISE: on rise, cnt<=1, stuck<=0, go to FIRST. No valid pulse.
  - FIRST: cnt increments. On fall, hi_cap<=cnt. On rise, period<=cnt, high_time<=hi_cap, prev_period<=cnt, valid<=1, cnt<=1, go to MEASURE; locked stays 0 because there is no previous measurement.
  - MEASURE: same counting and capture as FIRST. On rise, also locked <= (|cnt - prev_period| <= TOL), then prev_period<=cnt.
  - Timeout, in FIRST or MEASURE: if cnt reaches TIMEOUT with no rise, stuck<=1, locked<=0, cnt<=0, go to WAIT_RISE. period and high_time are held.
  - enable=0 in any state: go to IDLE, locked<=0, valid<=0. period, high_time and stuck are held.
- Timeout and rise in the same cycle: the rise wins and the measurement is taken normally.
- Counter arithmetic: unsigned and saturating at 2**CNT_WIDTH-1. This is unreachable when the TIMEOUT rule is respected.
- Abs difference: computed at CNT_WIDTH+1 bits so it cannot wrap.
- valid is high for exactly one cycle per accepted rising edge and is otherwise 0.
- A rise with no preceding fall (not possible after sync): high_time = period.

Decomposition:
- Package `clock_monitor_pkg`: typedef enum `mon_state_t` {IDLE, WAIT_RISE, FIRST, MEASURE}.
- Sub-module `sync_edge_detect` (parameter SYNC_STAGES; ports clk, rst, d, q, rise, fall): the synchronizer chain plus edge detect. It is reusable across the catalog.

Test Plan:
- sig_in period 10 clks, 5 high/5 low, enable=1 -> first valid after second rise with period=10, high_time=5, locked=0. Next valid -> locked=1. valid repeats every 10 clks.
- Duty 3 high/7 low -> period=10, high_time=3 on every valid.
- TIMEOUT=64, sig_in held low after lock -> stuck=1 and locked=0 exactly 64 cycles after the last rise. period stays 10. Restarting the clock clears stuck on the first rise; the next valid comes one period later.
- Period changes 10->14, TOL=0 -> first 14 measurement gives locked=0. Second consecutive 14 gives locked=1. With TOL=1, periods alternating 10/11 keep locked=1.
- rst pulsed between a fall and a rise -> all outputs 0 next cycle, no valid. Measurement restarts via WAIT_RISE and the first valid needs two further rises.
- enable dropped mid-period -> locked=0, no valid while low, period held. Re-enable -> resumes via WAIT_RISE.

Source files
------------

// File: rtl/clock_monitor_pkg.sv
// Shared types for the clock monitor: the measurement FSM state encoding.
package clock_monitor_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_RISE,
    FIRST,
    MEASURE
  } mon_state_t;

endpackage

// File: rtl/sync_edge_detect.sv
// Multi-flop synchronizer for an asynchronous level, followed by a history flop
// that turns the synchronized level into single-cycle rise/fall strobes.
module sync_edge_detect #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync <= '0;
      r_prev <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], d};
      r_prev <= r_sync[SYNC_STAGES-1];
    end
  end

  assign q    = r_sync[SYNC_STAGES-1];
  assign rise = q & ~r_prev;
  assign fall = ~q & r_prev;

endmodule

// File: rtl/clock_monitor.sv
// Measures period and high time of an asynchronous clock-like input in clk
// cycles, and flags lock (stable period) and stuck (no rising edge in time).
module clock_monitor
  import clock_monitor_pkg::*;
#(
  parameter int CNT_WIDTH   = 16,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 1024,
  parameter int TOL         = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic                 sig_in,
  output logic [CNT_WIDTH-1:0] period,
  output logic [CNT_WIDTH-1:0] high_time,
  output logic                 valid,
  output logic                 locked,
  output logic                 stuck
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX   = '1;
  localparam logic [CNT_WIDTH-1:0] TIMEOUT_C = CNT_WIDTH'(TIMEOUT);
  localparam logic [CNT_WIDTH:0]   TOL_C     = (CNT_WIDTH+1)'(TOL);

  mon_state_t           r_state, w_nextState;
  logic [CNT_WIDTH-1:0] r_cnt, w_cnt, w_cntInc;
  logic [CNT_WIDTH-1:0] r_hiCap, w_hiCap;
  logic                 r_fallSeen, w_fallSeen;
  logic [CNT_WIDTH-1:0] r_prevPeriod, w_prevPeriod;
  logic [CNT_WIDTH-1:0] r_period, w_period;
  logic [CNT_WIDTH-1:0] r_highTime, w_highTime;
  logic                 r_valid, w_valid;
  logic                 r_locked, w_locked;
  logic                 r_stuck, w_stuck;
  logic                 w_rise, w_fall, w_unusedSync;
  logic [CNT_WIDTH:0]   w_diffA, w_diffB, w_absDiff;

  sync_edge_detect #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (sig_in),
    .q   (w_unusedSync),
    .rise(w_rise),
    .fall(w_fall)
  );

  assign w_cntInc  = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + 1'b1;
  assign w_diffA   = {1'b0, r_cnt};
  assign w_diffB   = {1'b0, r_prevPeriod};
  assign w_absDiff = (w_diffA >= w_diffB) ? (w_diffA - w_diffB) : (w_diffB - w_diffA);

  always_comb begin
    w_nextState  = r_state;
    w_cnt        = r_cnt;
    w_hiCap      = r_hiCap;
    w_fallSeen   = r_fallSeen;
    w_prevPeriod = r_prevPeriod;
    w_period     = r_period;
    w_highTime   = r_highTime;
    w_valid      = 1'b0;
    w_locked     = r_locked;
    w_stuck      = r_stuck;
    if (!enable) begin
      w_nextState = IDLE;
      w_locked    = 1'b0;
      w_cnt       = '0;
    end else begin
      case (r_state)
        IDLE: begin
          w_cnt       = '0;
          w_nextState = WAIT_RISE;
        end
        WAIT_RISE: begin
          if (w_rise) begin
            w_cnt       = CNT_WIDTH'(1);
            w_stuck     = 1'b0;
            w_fallSeen  = 1'b0;
            w_nextState = FIRST;
          end
        end
        FIRST, MEASURE: begin
          // A rise beats a simultaneous timeout so the final period still counts.
          if (w_rise) begin
            w_period     = r_cnt;
            w_highTime   = r_fallSeen ? r_hiCap : r_cnt;
            w_prevPeriod = r_cnt;
            w_valid      = 1'b1;
            w_locked     = (r_state == MEASURE) && (w_absDiff <= TOL_C);
            w_cnt        = CNT_WIDTH'(1);
            w_fallSeen   = 1'b0;
            w_nextState  = MEASURE;
          end else if (r_cnt >= TIMEOUT_C) begin
            w_stuck     = 1'b1;
            w_locked    = 1'b0;
            w_cnt       = '0;
            w_nextState = WAIT_RISE;
          end else begin
            w_cnt = w_cntInc;
            if (w_fall) begin
              w_hiCap    = r_cnt;
              w_fallSeen = 1'b1;
            end
          end
        end
        default: w_nextState = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_hiCap      <= '0;
      r_fallSeen   <= 1'b0;
      r_prevPeriod <= '0;
      r_period     <= '0;
      r_highTime   <= '0;
      r_valid      <= 1'b0;
      r_locked     <= 1'b0;
      r_stuck      <= 1'b0;
    end else begin
      r_state      <= w_nextState;
      r_cnt        <= w_cnt;
      r_hiCap      <= w_hiCap;
      r_fallSeen   <= w_fallSeen;
      r_prevPeriod <= w_prevPeriod;
      r_period     <= w_period;
      r_highTime   <= w_highTime;
      r_valid      <= w_valid;
      r_locked     <= w_locked;
      r_stuck      <= w_stuck;
    end
  end

  assign period    = r_period;
  assign high_time = r_highTime;
  assign valid     = r_valid;
  assign locked    = r_locked;
  assign stuck     = r_stuck;

endmodule
